// File: rtl/sobel_pkg.sv
// ---------------------------------------------------------------------------
// sobel_pkg
// Shared definitions for the SOBEL result-memory reader and its buffer.
//   CSEL_*      layer-select encodings used on csel and on out_layer
//   IMG_*_DEF   default image geometry
//   rd_state_t  reader FSM state encoding
//   rd_word_t   one buffered pixel: data, the layer it came from, its address
//   next_layer  layer sequencing X -> Y -> C -> X
// ---------------------------------------------------------------------------
package sobel_pkg;

    localparam logic [1:0] CSEL_NONE = 2'b00;
    localparam logic [1:0] CSEL_X    = 2'b01;
    localparam logic [1:0] CSEL_Y    = 2'b10;
    localparam logic [1:0] CSEL_C    = 2'b11;

    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } rd_state_t;

    typedef struct packed {
        logic [7:0]  data;
        logic [1:0]  layer;
        logic [15:0] addr;
    } rd_word_t;

    localparam int TAG_W = $bits(rd_word_t);

    // Layers are read in the order X, Y, combined; after combined the
    // sequence restarts at X so the counters are ready for the next frame.
    function automatic logic [1:0] next_layer(input logic [1:0] layer);
        case (layer)
            CSEL_X:  return CSEL_Y;
            CSEL_Y:  return CSEL_C;
            default: return CSEL_X;
        endcase
    endfunction

endpackage

// File: rtl/sobel_result_reader_if.sv
// ---------------------------------------------------------------------------
// sobel_result_reader_if
// Pixel stream from the result reader to the host/scoreboard side.
//   out_valid  stream word valid            (master -> slave)
//   out_ready  downstream accept            (slave  -> master)
//   out_data   pixel value, 8 bits          (master -> slave)
//   out_layer  layer of the pixel 01/10/11  (master -> slave)
//   out_addr   pixel address row*W+col      (master -> slave)
//   out_last   final pixel of layer 11      (master -> slave)
// ---------------------------------------------------------------------------
interface sobel_result_reader_if;

    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_layer;
    logic [15:0] out_addr;
    logic        out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_layer,
        output out_addr,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_layer,
        input  out_addr,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/sobel_rd_fifo.sv
// ---------------------------------------------------------------------------
// sobel_rd_fifo
// Small synchronous FIFO holding tagged read data (data + layer + address).
// Shared with the image-side reader.
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   push       write push_data (ignored when full unless popping too)
//   push_data  entry to write
//   pop        remove the head entry (ignored when empty)
//   head_data  current head entry (stale when empty)
//   count      number of stored entries
//   empty      no entries stored
// ---------------------------------------------------------------------------
module sobel_rd_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 26,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle, so a full buffer can stream at one word per cycle.
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Storage, pointers and occupancy; the array is cleared on reset so the
    // head reads as zero straight after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sobel_result_reader.sv
// ---------------------------------------------------------------------------
// sobel_result_reader
// Waits for SOBEL to finish a frame (busy rise then fall), reads the X, Y and
// combined result layers back from the result memory, streams every pixel on
// a valid/ready port and keeps a 24-bit checksum per layer.
//   clk         clock, rising edge
//   reset       asynchronous, active-low reset
//   sobel_busy  SOBEL busy flag
//   crd         result-memory read strobe
//   csel        layer select 01 X / 10 Y / 11 combined, 00 while crd=0
//   caddr_rd    read address row*IMG_W+col
//   cdata_rd    read data, valid RD_LAT cycles after crd
//   out_if      pixel stream (master side)
//   chk_x/y/c   sums of accepted pixels per layer, mod 2^24
//   done        one-cycle pulse once the frame has been fully streamed
// ---------------------------------------------------------------------------
module sobel_result_reader
    import sobel_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int RD_LAT = 1,
    parameter int FDEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sobel_busy,
    output logic                          crd,
    output logic [1:0]                    csel,
    output logic [15:0]                   caddr_rd,
    input  logic [7:0]                    cdata_rd,
    sobel_result_reader_if.master         out_if,
    output logic [23:0]                   chk_x,
    output logic [23:0]                   chk_y,
    output logic [23:0]                   chk_c,
    output logic                          done
);

    localparam int          N         = IMG_W * IMG_H;
    localparam logic [15:0] LAST_ADDR = 16'(N - 1);
    localparam int          CW        = $clog2(FDEPTH + 1);

    rd_state_t     state;
    logic [15:0]   issue_addr;
    logic [1:0]    issue_layer;

    logic [RD_LAT-1:0] pipe_valid;
    logic [1:0]        pipe_layer [RD_LAT];
    logic [15:0]       pipe_addr  [RD_LAT];

    rd_word_t      push_word;
    rd_word_t      head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    int            inflight_cnt;
    logic          credit_ok;
    logic          read_start;
    logic          issue_now;

    // Returned data is tagged with the layer/address that was on the bus
    // when the read was issued, carried alongside in the in-flight pipe.
    assign push      = pipe_valid[RD_LAT-1];
    assign push_word = '{data: cdata_rd, layer: pipe_layer[RD_LAT-1], addr: pipe_addr[RD_LAT-1]};
    assign pop       = out_if.out_valid && out_if.out_ready;

    sobel_rd_fifo #(
        .DEPTH (FDEPTH),
        .WIDTH (TAG_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // The head fields are forced to zero while the buffer is empty so the
    // stream shows clean values between frames and after reset.
    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = fifo_empty ? 8'd0  : head.data;
    assign out_if.out_layer = fifo_empty ? 2'd0  : head.layer;
    assign out_if.out_addr  = fifo_empty ? 16'd0 : head.addr;
    assign out_if.out_last  = !fifo_empty && (head.layer == CSEL_C) && (head.addr == LAST_ADDR);

    // Reads still owed to the buffer: the one on the bus right now plus
    // every stage of the latency pipe.
    always_comb begin
        inflight_cnt = crd ? 1 : 0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (pipe_valid[i]) begin
                inflight_cnt = inflight_cnt + 1;
            end
        end
    end

    // Credit check: a new read is allowed only if every outstanding read
    // plus this one still fits even if the stream stalls from now on. A pop
    // in this cycle frees one slot immediately.
    always_comb begin
        credit_ok  = (int'(fifo_count) + inflight_cnt) < (FDEPTH + (pop ? 1 : 0));
        read_start = (state == ST_ARMED) && !sobel_busy;
        issue_now  = (read_start || (state == ST_READ)) && credit_ok;
    end

    // Latency pipe: stage 0 captures the read presented on the bus this
    // cycle, the last stage lines up with cdata_rd.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_layer[i] <= CSEL_NONE;
                pipe_addr[i]  <= '0;
            end
        end else begin
            pipe_valid[0] <= crd;
            pipe_layer[0] <= csel;
            pipe_addr[0]  <= caddr_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_layer[i] <= pipe_layer[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
            end
        end
    end

    // Main FSM with registered read bus and done pulse. The first read goes
    // out on the busy-fall edge itself so the first pixel reaches the stream
    // 1+RD_LAT cycles after READ is entered. Busy is only looked at in IDLE
    // and ARMED, so it is ignored for the rest of the frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            crd         <= 1'b0;
            csel        <= CSEL_NONE;
            caddr_rd    <= '0;
            issue_addr  <= '0;
            issue_layer <= CSEL_X;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;

            if (issue_now) begin
                crd      <= 1'b1;
                csel     <= issue_layer;
                caddr_rd <= issue_addr;
                if (issue_addr == LAST_ADDR) begin
                    issue_addr  <= '0;
                    issue_layer <= next_layer(issue_layer);
                end else begin
                    issue_addr <= issue_addr + 16'd1;
                end
            end else begin
                crd  <= 1'b0;
                csel <= CSEL_NONE;
            end

            case (state)
                ST_IDLE: begin
                    if (sobel_busy) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!sobel_busy) begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (issue_now && (issue_layer == CSEL_C) && (issue_addr == LAST_ADDR)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && (inflight_cnt == 0)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Checksums clear when a new frame's read phase starts and otherwise
    // only move on an accepted stream word, so they hold after done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_x <= '0;
            chk_y <= '0;
            chk_c <= '0;
        end else if (read_start) begin
            chk_x <= '0;
            chk_y <= '0;
            chk_c <= '0;
        end else if (pop) begin
            case (head.layer)
                CSEL_X:  chk_x <= chk_x + 24'(head.data);
                CSEL_Y:  chk_y <= chk_y + 24'(head.data);
                CSEL_C:  chk_c <= chk_c + 24'(head.data);
                default: chk_x <= chk_x;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_result_reader.sv
// ---------------------------------------------------------------------------
// tb_sobel_result_reader
// Scoreboard bench for sobel_result_reader on a 4x4 image with a behavioural
// result memory (one-cycle read latency).
// ---------------------------------------------------------------------------
module tb_sobel_result_reader;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int N      = IMG_W * IMG_H;
    localparam int RD_LAT = 1;
    localparam int FDEPTH = 2;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  layer;
        logic [15:0] addr;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sobel_busy = 1'b0;
    logic        crd;
    logic [1:0]  csel;
    logic [15:0] caddr_rd;
    logic [7:0]  cdata_rd = 8'd0;
    logic [23:0] chk_x;
    logic [23:0] chk_y;
    logic [23:0] chk_c;
    logic        done;

    sobel_result_reader_if outIf();

    int checks = 0;
    int errors = 0;
    int memMode = 0;
    int readyMode = 0;
    int readyIdx = 0;
    int wordCount = 0;
    int doneCount = 0;
    int crdCount = 0;
    int lastCount = 0;
    int doneBase = 0;
    int wordBase = 0;
    int lastBase = 0;
    logic [23:0] expX;
    logic [23:0] expY;
    logic [23:0] expC;
    exp_t sbQueue[$];

    logic        prevStall = 1'b0;
    logic [7:0]  prevData;
    logic [1:0]  prevLayer;
    logic [15:0] prevAddr;
    logic        prevLast;

    sobel_result_reader #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .RD_LAT (RD_LAT),
        .FDEPTH (FDEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sobel_busy (sobel_busy),
        .crd        (crd),
        .csel       (csel),
        .caddr_rd   (caddr_rd),
        .cdata_rd   (cdata_rd),
        .out_if     (outIf),
        .chk_x      (chk_x),
        .chk_y      (chk_y),
        .chk_c      (chk_c),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Layer contents: mode 0 is X=addr, Y=2*addr, C=255; mode 1 is all 255.
    function automatic logic [7:0] memValue(input int mode, input logic [1:0] layer, input logic [15:0] addr);
        logic [15:0] dbl;
        dbl = addr * 16'd2;
        if (mode == 1) return 8'd255;
        case (layer)
            2'b01:   return addr[7:0];
            2'b10:   return dbl[7:0];
            2'b11:   return 8'd255;
            default: return 8'd0;
        endcase
    endfunction

    // Result memory with one cycle of read latency.
    always @(posedge clk) begin
        if (crd) cdata_rd <= memValue(memMode, csel, caddr_rd);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Downstream ready patterns: 0 always ready, 1 repeating 1,0,0,1, 2 stalled.
    initial begin
        outIf.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: outIf.out_ready = 1'b1;
                1: begin
                    outIf.out_ready = ((readyIdx % 4) == 0) || ((readyIdx % 4) == 3);
                    readyIdx++;
                end
                default: outIf.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: bus rules, stall stability and scoreboard comparison.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (crd) crdCount++;
                if (done) doneCount++;
                checkOutput("cselRule", {31'd0, (crd ? (csel != 2'b00) : (csel == 2'b00))}, 1);
                if (prevStall) begin
                    checkOutput("stallValid", {31'd0, outIf.out_valid}, 1);
                    checkOutput("stallData", {24'd0, outIf.out_data}, {24'd0, prevData});
                    checkOutput("stallLayer", {30'd0, outIf.out_layer}, {30'd0, prevLayer});
                    checkOutput("stallAddr", {16'd0, outIf.out_addr}, {16'd0, prevAddr});
                    checkOutput("stallLast", {31'd0, outIf.out_last}, {31'd0, prevLast});
                end
                if (outIf.out_valid && outIf.out_ready) begin
                    wordCount++;
                    if (outIf.out_last) lastCount++;
                    if (sbQueue.size() == 0) begin
                        checkOutput("sbUnderflow", 1, 0);
                    end else begin
                        e = sbQueue.pop_front();
                        checkOutput("wordData", {24'd0, outIf.out_data}, {24'd0, e.data});
                        checkOutput("wordLayer", {30'd0, outIf.out_layer}, {30'd0, e.layer});
                        checkOutput("wordAddr", {16'd0, outIf.out_addr}, {16'd0, e.addr});
                        checkOutput("wordLast", {31'd0, outIf.out_last}, {31'd0, e.last});
                    end
                end
                prevStall = outIf.out_valid && !outIf.out_ready;
                prevData  = outIf.out_data;
                prevLayer = outIf.out_layer;
                prevAddr  = outIf.out_addr;
                prevLast  = outIf.out_last;
            end else begin
                prevStall = 1'b0;
            end
        end
    end

    // Queue the whole expected frame, then give SOBEL a busy rise and fall.
    task automatic applyStimulus(input int mode);
        exp_t e;
        memMode = mode;
        expX = '0;
        expY = '0;
        expC = '0;
        for (int l = 1; l <= 3; l++) begin
            for (int a = 0; a < N; a++) begin
                e.layer = 2'(l);
                e.addr  = 16'(a);
                e.data  = memValue(mode, e.layer, e.addr);
                e.last  = (l == 3) && (a == N - 1);
                sbQueue.push_back(e);
                case (l)
                    1:       expX = expX + 24'(e.data);
                    2:       expY = expY + 24'(e.data);
                    default: expC = expC + 24'(e.data);
                endcase
            end
        end
        doneBase = doneCount;
        wordBase = wordCount;
        lastBase = lastCount;
        @(posedge clk);
        #1 sobel_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 sobel_busy = 1'b0;
    endtask

    task automatic waitFrameDone(input string tag);
        int cyc;
        cyc = 0;
        while ((doneCount == doneBase) && (cyc < 2000)) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checkOutput({tag, "_doneSeen"}, {31'd0, (doneCount > doneBase)}, 1);
        repeat (5) @(negedge clk);
        #1;
        checkOutput({tag, "_donePulses"}, doneCount - doneBase, 1);
        checkOutput({tag, "_words"}, wordCount - wordBase, 3 * N);
        checkOutput({tag, "_lastCount"}, lastCount - lastBase, 1);
        checkOutput({tag, "_sbEmpty"}, sbQueue.size(), 0);
        checkOutput({tag, "_chkX"}, {8'd0, chk_x}, {8'd0, expX});
        checkOutput({tag, "_chkY"}, {8'd0, chk_y}, {8'd0, expY});
        checkOutput({tag, "_chkC"}, {8'd0, chk_c}, {8'd0, expC});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_crd"}, {31'd0, crd}, 0);
        checkOutput({tag, "_csel"}, {30'd0, csel}, 0);
        checkOutput({tag, "_caddr"}, {16'd0, caddr_rd}, 0);
        checkOutput({tag, "_valid"}, {31'd0, outIf.out_valid}, 0);
        checkOutput({tag, "_data"}, {24'd0, outIf.out_data}, 0);
        checkOutput({tag, "_layer"}, {30'd0, outIf.out_layer}, 0);
        checkOutput({tag, "_addr"}, {16'd0, outIf.out_addr}, 0);
        checkOutput({tag, "_last"}, {31'd0, outIf.out_last}, 0);
        checkOutput({tag, "_chk"}, {8'd0, chk_x | chk_y | chk_c}, 0);
        checkOutput({tag, "_done"}, {31'd0, done}, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int crdBase;
        int crdMid;
        int cyc;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] case 1: ramp frame, always ready");
        readyMode = 0;
        applyStimulus(0);
        waitFrameDone("c1");

        $display("[TB] case 2: ready pattern 1,0,0,1");
        readyIdx = 0;
        readyMode = 1;
        applyStimulus(0);
        waitFrameDone("c2");
        readyMode = 0;

        $display("[TB] case 3: stalled downstream after READ entry");
        readyMode = 2;
        @(posedge clk);
        applyStimulus(0);
        crdBase = crdCount;
        crdMid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (i == 9) crdMid = crdCount;
        end
        checkOutput("c3_readsAtMost", {31'd0, ((crdCount - crdBase) <= FDEPTH)}, 1);
        checkOutput("c3_readsSome", {31'd0, ((crdCount - crdBase) >= 1)}, 1);
        checkOutput("c3_crdLowLate", crdCount - crdMid, 0);
        checkOutput("c3_headValid", {31'd0, outIf.out_valid}, 1);
        readyMode = 0;
        waitFrameDone("c3");

        $display("[TB] case 4: reset after 10 words");
        applyStimulus(0);
        base = wordCount + 10;
        cyc = 0;
        while ((wordCount < base) && (cyc < 500)) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checkOutput("c4_tenWords", {31'd0, (wordCount >= base)}, 1);
        reset = 1'b0;
        sbQueue.delete();
        @(negedge clk);
        checkResetValues("c4");
        #1 reset = 1'b1;
        base = doneCount;
        crdBase = crdCount;
        repeat (20) @(negedge clk);
        #1;
        checkOutput("c4_noDone", doneCount - base, 0);
        checkOutput("c4_idleNoReads", crdCount - crdBase, 0);
        applyStimulus(0);
        waitFrameDone("c4");

        $display("[TB] case 5: busy pulses during READ, then a second frame");
        applyStimulus(0);
        repeat (4) @(posedge clk);
        #1 sobel_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1 sobel_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 sobel_busy = 1'b1;
        @(posedge clk);
        #1 sobel_busy = 1'b0;
        waitFrameDone("c5");
        base = doneCount;
        crdBase = crdCount;
        repeat (30) @(negedge clk);
        #1;
        checkOutput("c5_noSecondDone", doneCount - base, 0);
        checkOutput("c5_noExtraReads", crdCount - crdBase, 0);
        applyStimulus(0);
        waitFrameDone("c5b");

        $display("[TB] case 6: all-255 layers");
        applyStimulus(1);
        waitFrameDone("c6");
        checkOutput("c6_chkX4080", {8'd0, chk_x}, 4080);
        checkOutput("c6_chkC4080", {8'd0, chk_c}, 4080);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
